// File: rtl/fifo_rr_arbiter_pkg.sv
// fifo_arb_pkg: arbiter FSM state type and default parameter values
package fifo_arb_pkg;
  typedef enum logic {IDLE, LOCK} state_t;
  localparam int N_REQ_DEF = 4;
  localparam int DATA_W_DEF = 8;
  localparam int MAX_BURST_DEF = 4;
endpackage

// File: rtl/fifo_rr_arbiter_if.sv
// fifo_rr_arbiter_if: requester-side valid/ready bundle plus the single registered sink stream
// master: drives req_data/req_valid/out_ready, observes req_ready/out_data/out_src/out_valid
// slave:  the arbiter side of the same signals
interface fifo_rr_arbiter_if import fifo_arb_pkg::*; #(
  parameter int N_REQ = N_REQ_DEF,
  parameter int DATA_W = DATA_W_DEF
);
  localparam int SRC_W = $clog2(N_REQ);
  logic [N_REQ*DATA_W-1:0] req_data;
  logic [N_REQ-1:0] req_valid;
  logic [N_REQ-1:0] req_ready;
  logic [DATA_W-1:0] out_data;
  logic [SRC_W-1:0] out_src;
  logic out_valid;
  logic out_ready;
  modport master (
    output req_data, req_valid, out_ready,
    input  req_ready, out_data, out_src, out_valid
  );
  modport slave (
    input  req_data, req_valid, out_ready,
    output req_ready, out_data, out_src, out_valid
  );
endinterface

// File: rtl/fifo_rr_arbiter_rr_pick.sv
// rr_pick: first set request bit at or after i_start, wrapping modulo N
// i_req: request vector, i_start: scan start index, o_idx: winner (equals i_start when i_req is 0)
module rr_pick import fifo_arb_pkg::*; #(
  parameter int N = N_REQ_DEF,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] i_req,
  input  logic [W-1:0] i_start,
  output logic [W-1:0] o_idx
);
  logic [N-1:0] w_rot;
  logic [W:0] w_off;
  logic [W:0] w_sum;
  // rotate so that i_start lands on bit 0
  assign w_rot = N'({i_req, i_req} >> i_start);
  always_comb begin
    w_off = '0;
    for (int k = N - 1; k >= 0; k--) w_off = w_rot[k] ? (W+1)'(k) : w_off;
  end
  assign w_sum = {1'b0, i_start} + w_off;
  assign o_idx = W'(w_sum >= (W+1)'(N) ? w_sum - (W+1)'(N) : w_sum);
endmodule

// File: rtl/fifo_rr_arbiter.sv
// fifo_rr_arbiter: round-robin burst arbiter feeding one registered valid/ready sink
// clk, rst_n (async, active low); bus: requester beats in, registered beat + source index out
module fifo_rr_arbiter import fifo_arb_pkg::*; #(
  parameter int N_REQ = N_REQ_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int MAX_BURST = MAX_BURST_DEF,
  localparam int SRC_W = $clog2(N_REQ),
  localparam int CNT_W = $clog2(MAX_BURST + 1)
) (
  input logic clk,
  input logic rst_n,
  fifo_rr_arbiter_if.slave bus
);
  state_t r_state, w_state_nxt;
  logic [SRC_W-1:0] r_ptr, w_ptr_nxt;
  logic [SRC_W-1:0] r_lock, w_lock_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [SRC_W-1:0] w_lock_inc, w_g_inc, w_start, w_pick, w_g;
  logic [DATA_W-1:0] r_out_data, w_sel_data;
  logic [SRC_W-1:0] r_out_src;
  logic r_out_valid;
  logic w_load, w_any, w_lock_hit, w_xfer;
  assign w_load = !r_out_valid || bus.out_ready;
  assign w_any = |bus.req_valid;
  assign w_lock_hit = r_state == LOCK && bus.req_valid[r_lock];
  assign w_lock_inc = r_lock == SRC_W'(N_REQ - 1) ? '0 : r_lock + 1'b1;
  // a lock whose owner went idle hands over starting just past the owner
  assign w_start = r_state == LOCK ? w_lock_inc : r_ptr;
  rr_pick #(.N(N_REQ)) u_pick (
    .i_req(bus.req_valid),
    .i_start(w_start),
    .o_idx(w_pick)
  );
  assign w_g = w_lock_hit ? r_lock : w_pick;
  assign w_g_inc = w_g == SRC_W'(N_REQ - 1) ? '0 : w_g + 1'b1;
  assign w_xfer = w_load && w_any;
  assign w_sel_data = bus.req_data[w_g*DATA_W +: DATA_W];
  assign bus.req_ready = (rst_n && w_xfer) ? N_REQ'(1) << w_g : '0;
  assign bus.out_data = r_out_data;
  assign bus.out_src = r_out_src;
  assign bus.out_valid = r_out_valid;
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt = r_ptr;
    w_lock_nxt = r_lock;
    w_cnt_nxt = r_cnt;
    if (w_xfer && w_lock_hit) begin
      w_cnt_nxt = r_cnt + 1'b1;
      if (r_cnt + 1'b1 == CNT_W'(MAX_BURST)) begin
        w_ptr_nxt = w_lock_inc;
        w_state_nxt = IDLE;
      end
    end else if (w_load && r_state == LOCK) begin
      w_ptr_nxt = w_lock_inc;
      w_state_nxt = IDLE;
    end
    // a fresh grant (from IDLE or from a same-cycle release) opens a new burst
    if (w_xfer && !w_lock_hit) begin
      if (MAX_BURST > 1) begin
        w_lock_nxt = w_g;
        w_cnt_nxt = CNT_W'(1);
        w_state_nxt = LOCK;
      end else begin
        w_ptr_nxt = w_g_inc;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_ptr <= '0;
      r_lock <= '0;
      r_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr <= w_ptr_nxt;
      r_lock <= w_lock_nxt;
      r_cnt <= w_cnt_nxt;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data <= '0;
      r_out_src <= '0;
    end else begin
      if (w_load) r_out_valid <= w_xfer;
      if (w_xfer) begin
        r_out_data <= w_sel_data;
        r_out_src <= w_g;
      end
    end
  end
endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// tb_fifo_rr_arbiter: directed scenarios with a cycle-by-cycle behavioural model and an 8-deep sink fifo
module tb_fifo_rr_arbiter;
  localparam int NR = 4;
  localparam int MB = 2;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rd = 1'b1;
  int total = 0;
  int bad = 0;
  int acc = -1;
  int fifo_cnt = 0;
  int push = 0;
  int pop = 0;
  int m_owner = -1;
  int m_used = 0;
  int m_ptr = 0;
  logic e_ov = 1'b0;
  logic [7:0] e_od = '0;
  logic [1:0] e_os = '0;
  logic [7:0] src_q[NR][$];
  logic [7:0] fq[$];
  logic [7:0] rd_log[$];
  int grants[$];

  fifo_rr_arbiter_if #(.N_REQ(NR), .DATA_W(8)) bus ();
  fifo_rr_arbiter #(.N_REQ(NR), .DATA_W(8), .MAX_BURST(MB)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #10 clk = ~clk;
  assign bus.out_ready = fifo_cnt < 8;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] rd_at(input int i);
    return i < rd_log.size() ? 32'(rd_log[i]) : 32'hDEAD;
  endfunction

  function automatic logic [31:0] gr_at(input int i);
    return i < grants.size() ? 32'(grants[i]) : 32'hDEAD;
  endfunction

  // model: decide this cycle's grant from requester state, then advance as the upcoming edge will
  always @(negedge clk) begin
    int w, st;
    logic ld;
    push = 0;
    pop = 0;
    acc = -1;
    if (!rst_n) begin
      m_owner = -1;
      m_used = 0;
      m_ptr = 0;
      e_ov = 1'b0;
      e_od = '0;
      e_os = '0;
      fq.delete();
      chk("rst_req_ready", bus.req_ready, 0);
      chk("rst_out_valid", bus.out_valid, 0);
    end else begin
      chk("out_valid", bus.out_valid, e_ov);
      chk("out_data", bus.out_data, e_od);
      chk("out_src", bus.out_src, e_os);
      ld = !e_ov || bus.out_ready;
      w = -1;
      if (m_owner >= 0 && bus.req_valid[m_owner]) w = m_owner;
      else begin
        st = m_owner >= 0 ? (m_owner + 1) % NR : m_ptr;
        for (int k = NR - 1; k >= 0; k--) if (bus.req_valid[(st + k) % NR]) w = (st + k) % NR;
      end
      chk("req_ready", bus.req_ready, (ld && w >= 0) ? (32'd1 << w) : 0);
      if (rd && fq.size() > 0) begin
        rd_log.push_back(fq.pop_front());
        pop = 1;
      end
      if (bus.out_valid && bus.out_ready) begin
        fq.push_back(bus.out_data);
        push = 1;
      end
      if (ld && w >= 0) begin
        acc = w;
        grants.push_back(w);
        e_ov = 1'b1;
        e_od = bus.req_data[w*8 +: 8];
        e_os = 2'(w);
        if (w == m_owner) begin
          m_used++;
          if (m_used == MB) begin
            m_ptr = (w + 1) % NR;
            m_owner = -1;
          end
        end else begin
          if (m_owner >= 0) m_ptr = (m_owner + 1) % NR;
          if (MB > 1) begin
            m_owner = w;
            m_used = 1;
          end else m_ptr = (w + 1) % NR;
        end
      end else if (ld) begin
        e_ov = 1'b0;
        if (m_owner >= 0) begin
          m_ptr = (m_owner + 1) % NR;
          m_owner = -1;
        end
      end
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) fifo_cnt <= 0;
    else fifo_cnt <= fifo_cnt + push - pop;
  end

  task automatic drive();
    logic [NR-1:0] v;
    logic [NR*8-1:0] d;
    for (int i = 0; i < NR; i++) begin
      v[i] = src_q[i].size() > 0;
      d[i*8 +: 8] = v[i] ? src_q[i][0] : 8'h00;
    end
    bus.req_valid = v;
    bus.req_data = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (acc >= 0 && src_q[acc].size() > 0) void'(src_q[acc].pop_front());
    drive();
  endtask

  task automatic clear_src();
    for (int i = 0; i < NR; i++) src_q[i].delete();
    drive();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_src();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    rd_log.delete();
    grants.delete();
  endtask

  initial begin
    int n;
    clear_src();
    // reset
    repeat (2) @(posedge clk);
    #2;
    chk("reset_ready_low", bus.req_ready, 4'b0000);
    #1;
    rst_n = 1'b1;
    #2;
    chk("post_rst_out_valid", bus.out_valid, 0);
    chk("post_rst_ready", bus.req_ready, 4'b0000);
    chk("post_rst_out_data", bus.out_data, 8'h00);
    chk("post_rst_out_src", bus.out_src, 0);
    chk("post_rst_fifo_empty", fifo_cnt, 0);
    repeat (3) tick();
    // single requester
    do_reset();
    src_q[2] = '{8'h11, 8'h22, 8'h33};
    tick();
    #2;
    chk("single_ready", bus.req_ready, 4'b0100);
    chk("single_ov_before", bus.out_valid, 0);
    tick();
    #2;
    chk("single_ov_after", bus.out_valid, 1);
    chk("single_first_data", bus.out_data, 8'h11);
    chk("single_first_src", bus.out_src, 2);
    repeat (10) tick();
    chk("single_rd0", rd_at(0), 8'h11);
    chk("single_rd1", rd_at(1), 8'h22);
    chk("single_rd2", rd_at(2), 8'h33);
    chk("single_count", rd_log.size(), 3);
    // round robin with bursts
    do_reset();
    for (int k = 0; k < NR; k++)
      for (int s = 0; s < 4; s++) src_q[k].push_back(8'(s * 16 + k));
    repeat (25) tick();
    begin
      int exp_g[10] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
      logic [7:0] exp_d[10] = '{8'h00, 8'h10, 8'h01, 8'h11, 8'h02, 8'h12, 8'h03, 8'h13, 8'h20, 8'h30};
      for (int i = 0; i < 10; i++) begin
        chk($sformatf("rr_grant%0d", i), gr_at(i), exp_g[i]);
        chk($sformatf("rr_read%0d", i), rd_at(i), exp_d[i]);
      end
    end
    // early release
    do_reset();
    src_q[1] = '{8'hA1};
    src_q[3] = '{8'hB1, 8'hB2};
    tick();
    #2;
    chk("early_first_ready", bus.req_ready, 4'b0010);
    tick();
    #2;
    chk("early_handover_ready", bus.req_ready, 4'b1000);
    repeat (8) tick();
    chk("early_g0", gr_at(0), 1);
    chk("early_g1", gr_at(1), 3);
    chk("early_g2", gr_at(2), 3);
    chk("early_rd1", rd_at(1), 8'hB1);
    // backpressure
    do_reset();
    rd = 1'b0;
    for (int i = 0; i < 8; i++) src_q[0].push_back(8'hB0 + 8'(i));
    n = 0;
    while (!(fifo_cnt == 8 && src_q[0].size() == 0) && n < 40) begin
      tick();
      n++;
    end
    chk("bp_fill_in_time", n < 40, 1);
    src_q[1] = '{8'hA5};
    tick();
    tick();
    src_q[2] = '{8'hC3};
    for (int i = 0; i < 4; i++) begin
      tick();
      #2;
      chk("bp_ready_blocked", bus.req_ready, 4'b0000);
      chk("bp_data_stable", bus.out_data, 8'hA5);
      chk("bp_out_valid", bus.out_valid, 1);
    end
    rd = 1'b1;
    repeat (20) tick();
    chk("bp_rd0", rd_at(0), 8'hB0);
    chk("bp_rd7", rd_at(7), 8'hB7);
    chk("bp_rd8", rd_at(8), 8'hA5);
    chk("bp_rd9", rd_at(9), 8'hC3);
    // reset mid-burst
    do_reset();
    src_q[3] = '{8'hD0, 8'hD1};
    tick();
    tick();
    #2;
    chk("mid_out_valid", bus.out_valid, 1);
    chk("mid_out_src", bus.out_src, 3);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", bus.out_valid, 0);
    chk("mid_rst_ready", bus.req_ready, 4'b0000);
    clear_src();
    src_q[0] = '{8'hE0};
    src_q[3] = '{8'hE3};
    tick();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    grants.delete();
    rd_log.delete();
    #2;
    chk("mid_restart_ready", bus.req_ready, 4'b0001);
    repeat (6) tick();
    chk("mid_g0", gr_at(0), 0);
    chk("mid_g1", gr_at(1), 3);
    chk("mid_rd0", rd_at(0), 8'hE0);
    chk("mid_rd1", rd_at(1), 8'hE3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
